dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug master.
- Arbitrates round-robin on contention and issues one access per cycle to the memory.
- Returns registered read data with a one-cycle valid pulse.
- Supports a port-1 bus lock for burst loads, bounded by a starvation limit so the CPU cannot be blocked indefinitely.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_arbiter_if.sv | 60 ++++++
 rtl/dmem_arbiter_rr.sv | 39 +++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// Port indices, arbiter states and the request bundle.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   localparam int CPU_PORT = 0;
   localparam int LDR_PORT = 1;

   typedef enum logic {
      OPEN,
      LOCKED
   } arb_state_t;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters and memory.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              p0_req;
   logic              p1_req;
   logic              p0_we;
   logic              p1_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_lock;

   logic              p0_gnt;
   logic              p1_gnt;
   logic              p0_rvalid;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p0_rdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p0_err;
   logic              p1_err;
   logic              cpu_stall;

   logic              mem_MemWrite;
   logic              mem_Memread;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_writeData;
   logic [DATA_W-1:0] mem_readData;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we,
      input  p0_addr, p1_addr,
      input  p0_wdata, p1_wdata, p1_lock,
      output p0_gnt, p1_gnt,
      output p0_rvalid, p1_rvalid,
      output p0_rdata, p1_rdata,
      output p0_err, p1_err, cpu_stall,
      output mem_MemWrite, mem_Memread,
      output mem_address, mem_writeData,
      input  mem_readData
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we,
      output p0_addr, p1_addr,
      output p0_wdata, p1_wdata, p1_lock,
      input  p0_gnt, p1_gnt,
      input  p0_rvalid, p1_rvalid,
      input  p0_rdata, p1_rdata,
      input  p0_err, p1_err, cpu_stall,
      input  mem_MemWrite, mem_Memread,
      input  mem_address, mem_writeData,
      output mem_readData
   );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant with a force input
// for port 0 and a hold input that reserves port 1.
module rr_arbiter2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   input  logic force0,
   input  logic hold1,
   output logic gnt0,
   output logic gnt1
);

   logic sel_force;
   logic sel_hold;
   logic sel_both;

   assign sel_force = force0;
   assign sel_hold  = ~force0 & hold1;
   assign sel_both  = ~force0 & ~hold1 & req0 & req1;

   // Force beats hold; otherwise ptr breaks ties.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (1'b1)
         sel_force: gnt0 = 1'b1;
         sel_hold:  gnt1 = req1;
         sel_both: begin
            gnt0 = ~ptr;
            gnt1 = ptr;
         end
         default: begin
            gnt0 = req0;
            gnt1 = req1;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the MEM stage (port 0)
// and the loader (port 1), with lock and anti-starvation.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 8
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
   localparam logic [CW-1:0] FORCE_AT = CW'(MAX_WAIT - 1);
   localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

   arb_state_t        state;
   logic              rr_ptr;
   logic [CW-1:0]     wait_cnt;

   logic              req0;
   logic              req1;
   logic              force0;
   logic              gnt0;
   logic              gnt1;
   logic              any_gnt;
   logic              oob;
   dmem_req_t         r0;
   dmem_req_t         r1;
   dmem_req_t         sel;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata0;
   logic [DATA_W-1:0] rdata1;
   logic              rv0;
   logic              rv1;
   logic              err0;
   logic              err1;

   // Reset masks requests so nothing is issued while it is held.
   assign req0   = bus.p0_req & ~rst;
   assign req1   = bus.p1_req & ~rst;
   assign force0 = req0 & (wait_cnt == FORCE_AT);

   rr_arbiter2 u_rr (
      .req0   (req0),
      .req1   (req1),
      .ptr    (rr_ptr),
      .force0 (force0),
      .hold1  (state == LOCKED),
      .gnt0   (gnt0),
      .gnt1   (gnt1)
   );

   assign r0 = '{we:    bus.p0_we,
                 addr:  bus.p0_addr,
                 wdata: bus.p0_wdata};
   assign r1 = '{we:    bus.p1_we,
                 addr:  bus.p1_addr,
                 wdata: bus.p1_wdata};

   assign sel     = gnt1 ? r1 : r0;
   assign any_gnt = gnt0 | gnt1;
   assign oob     = sel.addr >= LIMIT;

   assign bus.p0_gnt    = gnt0;
   assign bus.p1_gnt    = gnt1;
   assign bus.cpu_stall = bus.p0_req & ~gnt0;

   assign bus.mem_MemWrite  = any_gnt & sel.we & ~oob;
   assign bus.mem_Memread   = any_gnt & ~sel.we & ~oob;
   assign bus.mem_address   = any_gnt ? sel.addr : addr_q;
   assign bus.mem_writeData = any_gnt ? sel.wdata : wdata_q;

   assign bus.p0_rdata  = rdata0;
   assign bus.p1_rdata  = rdata1;
   assign bus.p0_rvalid = rv0;
   assign bus.p1_rvalid = rv1;
   assign bus.p0_err    = err0;
   assign bus.p1_err    = err1;

   // Lock state, round-robin pointer and starvation count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= OPEN;
         rr_ptr   <= 1'(CPU_PORT);
         wait_cnt <= '0;
      end else begin
         if (gnt0)
            rr_ptr <= 1'(LDR_PORT);
         else if (gnt1)
            rr_ptr <= 1'(CPU_PORT);

         if (gnt0)
            wait_cnt <= '0;
         else if (req0 && wait_cnt != SAT)
            wait_cnt <= wait_cnt + 1'b1;

         unique case (state)
            OPEN:
               if (gnt1 & bus.p1_lock)
                  state <= LOCKED;
            LOCKED:
               if (force0 | ~bus.p1_lock)
                  state <= OPEN;
            default: state <= OPEN;
         endcase
      end
   end

   // Read capture, response pulses and held bus values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata0  <= '0;
         rdata1  <= '0;
         rv0     <= 1'b0;
         rv1     <= 1'b0;
         err0    <= 1'b0;
         err1    <= 1'b0;
      end else begin
         rv0  <= 1'b0;
         rv1  <= 1'b0;
         err0 <= gnt0 & oob;
         err1 <= gnt1 & oob;
         if (any_gnt) begin
            addr_q  <= sel.addr;
            wdata_q <= sel.wdata;
         end
         if (gnt0 & ~oob & ~sel.we) begin
            rdata0 <= bus.mem_readData;
            rv0    <= 1'b1;
         end
         if (gnt1 & ~oob & ~sel.we) begin
            rdata1 <= bus.mem_readData;
            rv1    <= 1'b1;
         end
      end
   end

endmodule
